display_scan_reader: RTL and testbench
======================================

Name: display_scan_reader

Overview:
Consumer end of the display mux interface. Drives the one-hot 5-bit select into mux_5to1 and waits for the mux's registered output to settle. Captures each of the five display channels (voltage, current, power, temperature, efficiency) and streams them out in order as a frame over a valid/ready handshake. It replaces the hard-wired select and lets downstream logic (serialiser, logger) read all telemetry channels.

Parameters:
DATA_W, 12, width of display word / mux_data / out_data
NUM_CH, 5, channels per frame; select width equals NUM_CH (one-hot)
SETTLE, 2, cycles between a select update and capture of mux_data; legal range 2..15

Ports:
clk  in  1  system clock (wb_clk_i at top level)
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = scan frames continuously; sampled in IDLE and at end of frame
mux_data  in  DATA_W  registered output of display mux
select  out  NUM_CH  one-hot channel select to display mux
out_valid  out  1  out_data/out_ch/out_last valid
out_ready  in  1  downstream accepts word when high with out_valid
out_data  out  DATA_W  captured channel value
out_ch  out  3  channel index 0..NUM_CH-1 (0 = voltage … 4 = efficiency)
out_last  out  1  high with out_valid on last channel of frame
frame_done  out  1  one-cycle pulse after last word accepted
frame_count  out  16  completed frames, wraps 0xFFFF->0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, select=00001, out_valid=0, out_data=0, out_ch=0, out_last=0, frame_done=0, frame_count=0, busy=0, settle counter=0. Reset applies mid-frame with no completion. The partial frame is discarded and frame_count is unchanged from 0.
- States: IDLE, SETTLE, SEND.
- IDLE: when enable=1 at edge k, set select<=00001, ch<=0, cnt<=SETTLE-1, go SETTLE. Otherwise stay; select holds its last value.
- SETTLE: decrement cnt each cycle. At the edge where cnt==0: out_data<=mux_data, out_ch<=ch, out_last<=(ch==NUM_CH-1), out_valid<=1, go SEND. Capture therefore happens at edge k+SETTLE. mux_data is registered by the mux at k+1, which is why SETTLE>=2.
- SEND: out_data, out_ch and out_last are held stable while out_valid=1 and out_ready=0. No timeout.
- Handshake in SEND: at the edge with out_ready=1, set out_valid<=0 and out_last<=0.
  - If ch<NUM_CH-1: select<=select<<1, ch<=ch+1, cnt<=SETTLE-1, go SETTLE.
  - If ch==NUM_CH-1: frame_done<=1 (for exactly one cycle), frame_count<=frame_count+1. Then, if enable=1 at that edge, select<=00001, ch<=0, go SETTLE; else go IDLE.
- out_ready while out_valid=0 is ignored.
- enable deasserted mid-frame does not abort; the frame completes and the block then idles.
- Throughput with out_ready tied high: one word per SETTLE+1 cycles.
  - First out_valid is visible after edge k+SETTLE.
  - The last handshake of a frame is at edge k+NUM_CH*(SETTLE+1).
  - Defaults: 15 cycles per frame; back-to-back frame period is 15 cycles.
- select is always exactly one-hot, never 0 and never multi-hot.
- mux_data is sampled only at capture edges; changes at other times do not affect out_data.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, enable=0 → select=00001, out_valid=0, frame_count=0, busy=0, held for 20 cycles.
- Single frame with ideal sink: hold mux_data to 0x101,0x202,0x303,0x404,0x505 per select, out_ready=1, pulse enable at edge k, drop after → five words ch0..4 with those values at edges k+2,k+5,k+8,k+11,k+14. out_last only with 0x505, frame_done high one cycle after edge k+15, frame_count=1, then IDLE.
- Backpressure: out_ready=0 for 10 cycles on ch2 → out_valid, out_data=0x303 and out_ch=2 stay stable, select stays 00100; raising out_ready resumes with ch3 three cycles later.
- Continuous scan: enable=1 for 4 frames → frame_count=4, 20 words, frame_done pulses 15 cycles apart. Preload frame_count-like wrap by running 65536 frames in fast-sim, or force the counter via backdoor to 0xFFFF, then complete a frame → frame_count=0.
- Enable drop mid-frame: deassert enable during ch1 → the frame still delivers ch2..ch4, then busy=0 and no new frame starts.
- Reset mid-operation: assert rst_n=0 during SEND of ch3 with out_ready=0 → next cycle out_valid=0, select=00001, frame_done never pulses, frame_count=0.

Source files
------------

// File: rtl/display_scan_reader_if.sv
// Word stream from display_scan_reader to its consumer (serialiser, logger).
// A word moves on the rising clk edge where out_valid and out_ready are both high.
// While out_valid is high, out_data/out_ch/out_last are stable and out_valid
// will not drop until that transfer happens. out_ready may change freely and
// is ignored while out_valid is low.
interface display_scan_reader_if #(
  parameter int DATA_W = 12
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_ch;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/display_scan_reader.sv
// Steps a one-hot select through the display mux, waits for the registered mux
// output to settle, and streams one frame of channel words per scan.
module display_scan_reader #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 5,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [DATA_W-1:0]    mux_data_i,
  output logic [NUM_CH-1:0]    select_o,
  display_scan_reader_if.master out_if,
  output logic                 frame_done_o,
  output logic [15:0]          frame_count_o,
  output logic                 busy_o,
  output logic [1:0]           state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;

  localparam logic [3:0]        CNT_INIT  = 4'(SETTLE - 1);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] SEL_FIRST = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ch_q, ch_d;
  logic [NUM_CH-1:0] select_q, select_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        out_ch_q, out_ch_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [15:0]       count_q, count_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    select_d = select_q;
    data_d   = data_q;
    out_ch_d = out_ch_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          select_d = SEL_FIRST;
          ch_d     = 3'd0;
          cnt_d    = CNT_INIT;
          state_d  = S_SETTLE;
        end
      end

      // The mux registers its output one edge after select moves, so the
      // capture waits SETTLE edges from the select update.
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          data_d   = mux_data_i;
          out_ch_d = ch_q;
          last_d   = (ch_q == LAST_CH);
          valid_d  = 1'b1;
          state_d  = S_SEND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_SEND: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (ch_q != LAST_CH) begin
            select_d = {select_q[NUM_CH-2:0], 1'b0};
            ch_d     = ch_q + 3'd1;
            cnt_d    = CNT_INIT;
            state_d  = S_SETTLE;
          end else begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
            // enable is only looked at here and in IDLE, so a frame never aborts.
            if (enable_i) begin
              select_d = SEL_FIRST;
              ch_d     = 3'd0;
              cnt_d    = CNT_INIT;
              state_d  = S_SETTLE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      ch_q     <= 3'd0;
      select_q <= SEL_FIRST;
      data_q   <= '0;
      out_ch_q <= 3'd0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      select_q <= select_d;
      data_q   <= data_d;
      out_ch_q <= out_ch_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign select_o         = select_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = out_ch_q;
  assign out_if.out_last  = last_q;
  assign frame_done_o     = done_q;
  assign frame_count_o    = count_q;
  assign busy_o           = (state_q != S_IDLE);
  assign state_o          = state_q;

endmodule

// File: tb/tb_display_scan_reader.sv
// Directed bench for display_scan_reader with a registered display-mux model
// and a per-channel vector table.
module tb_display_scan_reader;
  localparam int DATA_W = 12;
  localparam int NUM_CH = 5;
  localparam int SETTLE = 2;

  typedef struct {
    logic [DATA_W-1:0] mux_val;
    logic [2:0]        exp_ch;
    logic              exp_last;
    logic [NUM_CH-1:0] exp_sel;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] mux_data = '0;
  logic [DATA_W-1:0] mux_xor = '0;
  logic [NUM_CH-1:0] select;
  logic              frame_done;
  logic [15:0]       frame_count;
  logic              busy;
  logic [1:0]        state;

  vec_t              vecs[NUM_CH];
  logic [DATA_W-1:0] exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                cyc = 0;

  display_scan_reader_if #(.DATA_W(DATA_W)) out_if ();

  display_scan_reader #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .mux_data_i   (mux_data),
    .select_o     (select),
    .out_if       (out_if.master),
    .frame_done_o (frame_done),
    .frame_count_o(frame_count),
    .busy_o       (busy),
    .state_o      (state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] sel_val(input logic [NUM_CH-1:0] s);
    for (int i = 0; i < NUM_CH; i++) if (s[i]) return vecs[i].mux_val;
    return 12'hFFF;
  endfunction

  // Display mux model: output registered one edge after select.
  always @(posedge clk) mux_data <= sel_val(select) ^ mux_xor;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    while (!out_if.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("valid_within_budget", 32'(out_if.out_valid), 32'd1);
    c = cyc;
  endtask

  // Consumes one frame whose start edge is k. hold_ch stalls that word for
  // 10 cycles with noise on mux_data; drop_ch deasserts enable on that word.
  task automatic run_frame(input int k, input int hold_ch, input int drop_ch,
                           input logic [15:0] exp_count, input logic exp_busy_after,
                           output int h_last);
    int exp_c;
    int c;
    logic [DATA_W-1:0] exp_data;
    exp_c = k + SETTLE;
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(vecs[i].mux_val);
    for (int i = 0; i < NUM_CH; i++) begin
      wait_valid(c);
      check("word_cycle", 32'(c), 32'(exp_c));
      exp_data = exp_q.pop_front();
      check("out_data", 32'(out_if.out_data), 32'(exp_data));
      check("out_ch", 32'(out_if.out_ch), 32'(vecs[i].exp_ch));
      check("out_last", 32'(out_if.out_last), 32'(vecs[i].exp_last));
      check("select", 32'(select), 32'(vecs[i].exp_sel));
      check("busy_in_frame", 32'(busy), 32'd1);
      check("frame_done_in_frame", 32'(frame_done), 32'd0);
      if (i == drop_ch) enable = 1'b0;
      if (i == hold_ch) begin
        for (int j = 0; j < 10; j++) begin
          mux_xor = 12'($urandom_range(1, 4095));
          tick();
          check("hold_valid", 32'(out_if.out_valid), 32'd1);
          check("hold_data", 32'(out_if.out_data), 32'(exp_data));
          check("hold_ch", 32'(out_if.out_ch), 32'(vecs[i].exp_ch));
          check("hold_select", 32'(select), 32'(vecs[i].exp_sel));
        end
        mux_xor = '0;
      end
      out_if.out_ready = 1'b1;
      tick();
      out_if.out_ready = 1'b0;
      check("valid_after_accept", 32'(out_if.out_valid), 32'd0);
      exp_c = cyc + SETTLE;
    end
    h_last = cyc;
    check("frame_done", 32'(frame_done), 32'd1);
    check("frame_count", 32'(frame_count), 32'(exp_count));
    check("busy_after_frame", 32'(busy), 32'(exp_busy_after));
    tick();
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask

  initial begin
    int k;
    int h;
    int prev_h;
    int c;

    vecs[0] = '{12'h101, 3'd0, 1'b0, 5'b00001};
    vecs[1] = '{12'h202, 3'd1, 1'b0, 5'b00010};
    vecs[2] = '{12'h303, 3'd2, 1'b0, 5'b00100};
    vecs[3] = '{12'h404, 3'd3, 1'b0, 5'b01000};
    vecs[4] = '{12'h505, 3'd4, 1'b1, 5'b10000};
    out_if.out_ready = 1'b0;

    // Reset and idle, with out_ready high while nothing is valid
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_select", 32'(select), 32'h1);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_data", 32'(out_if.out_data), 32'd0);
    check("rst_ch", 32'(out_if.out_ch), 32'd0);
    check("rst_last", 32'(out_if.out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_hold", 32'({select, out_if.out_valid, busy, frame_count}),
            32'({5'b00001, 1'b0, 1'b0, 16'd0}));
    end
    out_if.out_ready = 1'b0;

    // Single frame, enable pulsed for one edge
    enable = 1'b1;
    k = cyc + 1;
    tick();
    enable = 1'b0;
    run_frame(k, -1, -1, 16'd1, 1'b0, h);
    check("single_frame_end_edge", 32'(h), 32'(k + 15));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_after_single", 32'({busy, out_if.out_valid}), 32'd0);
    end

    // Backpressure on ch2
    enable = 1'b1;
    k = cyc + 1;
    tick();
    enable = 1'b0;
    run_frame(k, 2, -1, 16'd2, 1'b0, h);

    // Continuous scan of four frames from a clean count
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("count_cleared", 32'(frame_count), 32'd0);
    enable = 1'b1;
    k = cyc + 1;
    tick();
    prev_h = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(k, -1, (f == 3) ? 4 : -1, 16'(f + 1), (f != 3), h);
      if (f > 0) check("frame_period", 32'(h - prev_h), 32'd15);
      prev_h = h;
      k = h;
    end
    tick();
    check("idle_after_continuous", 32'(busy), 32'd0);

    // Enable dropped during ch1: frame completes, no new frame
    enable = 1'b1;
    k = cyc + 1;
    tick();
    run_frame(k, -1, 1, 16'd5, 1'b0, h);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_after_drop", 32'({busy, out_if.out_valid, frame_done}), 32'd0);
    end

    // Frame counter wrap
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    check("count_preload", 32'(frame_count), 32'hFFFF);
    enable = 1'b1;
    k = cyc + 1;
    tick();
    enable = 1'b0;
    run_frame(k, -1, -1, 16'd0, 1'b0, h);

    // Reset while ch3 is stalled
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(c);
      check("partial_data", 32'(out_if.out_data), 32'(vecs[i].mux_val));
      out_if.out_ready = 1'b1;
      tick();
      out_if.out_ready = 1'b0;
    end
    wait_valid(c);
    check("partial_ch3_data", 32'(out_if.out_data), 32'h404);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_if.out_valid), 32'd0);
    check("midrst_select", 32'(select), 32'h1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_done_after_rst", 32'({frame_done, busy, frame_count}), 32'd0);
    end
    out_if.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
